// File: rtl/ram_data_port_arbiter_pkg.sv
// ram_data_port_arbiter_pkg
//   Shared definitions for the RAM data-port arbiter: default widths, the
//   arbiter state encoding, the rejected top-of-memory address and the
//   requester index constants.
package ram_data_port_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A 16-bit access at the last byte address would straddle the top of memory.
  localparam logic [DEF_ADDR_WIDTH-1:0] BAD_ADDR = '1;

  localparam logic REQ_CPU    = 1'b0;  // CPU load/store unit
  localparam logic REQ_LOADER = 1'b1;  // program loader / peripheral DMA

endpackage

// File: rtl/ram_data_port_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin selector.
//   Ports:
//     req    in  2  pending requests
//     rr_ptr in  1  requester that has priority this time
//     owner  out 1  selected requester (rr_ptr if it requests, else the other)
//     any    out 1  at least one request is pending
module rr_pick2
  import ram_data_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       owner,
  output logic       any
);

  always_comb begin
    any   = |req;
    owner = req[rr_ptr] ? rr_ptr : ~rr_ptr;
  end

endmodule

// File: rtl/ram_data_port_arbiter.sv
// ram_data_port_arbiter
//   Shares the RAM's single data port between the CPU load/store unit
//   (requester 0) and the program loader / DMA (requester 1). Round-robin
//   arbitration, optional locked bursts of up to MAX_BURST grants, and
//   rejection of 16-bit accesses at the all-ones byte address.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     req, lock [1:0]      per-requester request / burst hold
//     we0/1, addr0/1,
//     wdata0/1             per-requester transaction
//     gnt [1:0]            one-hot grant; transaction taken at end of cycle
//     rvalid, err [1:0]    read-done / rejected pulse, one cycle after gnt
//     rdata                registered read data
//     ramAddr, ramInData,
//     ramWriteEn           to the RAM data port
//     ramDataOut           combinational read data from the RAM
module ram_data_port_arbiter
  import ram_data_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            lock,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [1:0]            err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0] ramInData,
  output logic                  ramWriteEn,
  input  logic [DATA_WIDTH-1:0] ramDataOut
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t                state_reg, state_next;
  logic                  owner_reg, owner_next;
  logic                  rr_ptr_reg, rr_ptr_next;
  logic [7:0]            burst_cnt_reg, burst_cnt_next;
  logic [1:0]            rvalid_reg, err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic                  pick_owner, pick_any;
  logic                  granting, bad;
  logic                  we_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic [1:0]            owner_onehot;

  rr_pick2 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .owner  (pick_owner),
    .any    (pick_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_onehot
      assign owner_onehot[gi] = (owner_reg == 1'(gi));
    end
  endgenerate

  // Owner's transaction and the RAM port. Everything is gated by the state
  // register, so an asynchronous reset drops the RAM strobe immediately.
  always_comb begin
    granting   = (state_reg == GRANT);
    addr_mux   = (owner_reg == REQ_LOADER) ? addr1  : addr0;
    wdata_mux  = (owner_reg == REQ_LOADER) ? wdata1 : wdata0;
    we_mux     = (owner_reg == REQ_LOADER) ? we1    : we0;
    bad        = (addr_mux == '1);
    gnt        = granting ? owner_onehot : 2'b00;
    ramAddr    = granting ? addr_mux  : '0;
    ramInData  = granting ? wdata_mux : '0;
    ramWriteEn = granting & we_mux & ~bad;
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next     = GRANT;
          owner_next     = pick_owner;
          burst_cnt_next = 8'd0;
        end
      end
      GRANT: begin
        // A locked owner keeps the port while it still requests and has
        // budget left; otherwise priority passes to the other requester.
        if (lock[owner_reg] && req[owner_reg] && (burst_cnt_reg < BURST_LAST)) begin
          burst_cnt_next = burst_cnt_reg + 8'd1;
        end else begin
          state_next     = IDLE;
          rr_ptr_next    = ~owner_reg;
          burst_cnt_next = 8'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= REQ_CPU;
      rr_ptr_reg    <= 1'b0;
      burst_cnt_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Response registers: rvalid/err pulse one cycle after the grant; rdata
  // holds the last read result (zero after a rejected access).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg <= 2'b00;
      err_reg    <= 2'b00;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= 2'b00;
      err_reg    <= 2'b00;
      if (granting) begin
        if (bad) begin
          err_reg   <= owner_onehot;
          rdata_reg <= '0;
        end else if (!we_mux) begin
          rvalid_reg <= owner_onehot;
          rdata_reg  <= ramDataOut;
        end
      end
    end
  end

  assign rvalid = rvalid_reg;
  assign err    = err_reg;
  assign rdata  = rdata_reg;

endmodule

// File: tb/tb_ram_data_port_arbiter.sv
// tb_ram_data_port_arbiter
//   Directed bench for ram_data_port_arbiter with a byte-wide RAM model, a
//   per-cycle reference model of grants/responses, and literal checks of the
//   grant and response logs for each scenario.
module tb_ram_data_port_arbiter;
  import ram_data_port_arbiter_pkg::*;

  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00, lock = 2'b00;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  gnt, rvalid, err;
  logic [15:0] rdata, ramAddr, ramInData, ramDataOut;
  logic        ramWriteEn;

  always #5 clk = ~clk;

  ram_data_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata),
    .ramAddr(ramAddr), .ramInData(ramInData), .ramWriteEn(ramWriteEn),
    .ramDataOut(ramDataOut)
  );

  typedef struct { logic [15:0] a; logic we; logic [15:0] d; logic lk; } txn_t;
  typedef struct { logic [15:0] a; logic [15:0] d; } pre_t;
  typedef struct { int cyc; int own; } glog_t;
  typedef struct { int cyc; logic [3:0] kind; logic [15:0] d; } rlog_t;

  txn_t  q0[$], q1[$];
  pre_t  pre_ram_q[$], pre_mod_q[$];
  glog_t glog[$];
  rlog_t rlog[$];
  int    we_count, both_cnt, frq0, frq1, cyc;
  int    n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- RAM (little-endian 16-bit port over bytes) -------------
  logic [7:0]  mem [0:65535];
  logic [15:0] ram_a1;
  assign ram_a1     = ramAddr + 16'd1;
  assign ramDataOut = {mem[ram_a1], mem[ramAddr]};

  initial begin
    pre_t p;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    forever begin
      @(posedge clk);
      if (ramWriteEn) begin
        mem[ramAddr] <= ramInData[7:0];
        mem[ram_a1]  <= ramInData[15:8];
      end
      while (pre_ram_q.size() > 0) begin
        p = pre_ram_q.pop_front();
        mem[p.a]         <= p.d[7:0];
        mem[p.a + 16'd1] <= p.d[15:8];
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_t p;
    p.a = a; p.d = d;
    pre_ram_q.push_back(p);
    pre_mod_q.push_back(p);
  endtask

  // ---------------- requester drivers ----------------
  initial begin
    logic [1:0] g;
    forever begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      if (g[0] && q0.size() > 0) q0.delete(0);
      if (g[1] && q1.size() > 0) q1.delete(0);
      if (q0.size() > 0) begin
        req[0] = 1'b1; lock[0] = q0[0].lk; we0 = q0[0].we; addr0 = q0[0].a; wdata0 = q0[0].d;
      end else begin
        req[0] = 1'b0; lock[0] = 1'b0;
      end
      if (q1.size() > 0) begin
        req[1] = 1'b1; lock[1] = q1[0].lk; we1 = q1[0].we; addr1 = q1[0].a; wdata1 = q1[0].d;
      end else begin
        req[1] = 1'b0; lock[1] = 1'b0;
      end
    end
  end

  task automatic push(input int who, input logic [15:0] a, input logic we,
                      input logic [15:0] d, input logic lk);
    txn_t t;
    t.a = a; t.we = we; t.d = d; t.lk = lk;
    if (who == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [0:65535];
  logic [1:0]  e_gnt = 2'b00, e_rvalid = 2'b00, e_err = 2'b00;
  logic [15:0] e_rdata = '0;
  logic        m_ptr = 1'b0;
  int          m_run = 0;
  logic [1:0]  s_g = 2'b00, s_req = 2'b00, s_lock = 2'b00;
  logic        s_we = 1'b0;
  logic [15:0] s_addr = '0, s_wdata = '0;

  // Clock-edge side: what the port must do next, from the rules of grant
  // continuation, round-robin choice and access outcome.
  initial begin
    pre_t p;
    int o;
    logic [15:0] a1;
    for (int i = 0; i < 65536; i++) m_mem[i] = 8'h00;
    cyc = 0;
    forever begin
      @(posedge clk);
      while (pre_mod_q.size() > 0) begin
        p = pre_mod_q.pop_front();
        m_mem[p.a] = p.d[7:0];
        m_mem[p.a + 16'd1] = p.d[15:8];
      end
      if (!rst_n) begin
        e_gnt = 2'b00; e_rvalid = 2'b00; e_err = 2'b00; e_rdata = '0;
        m_ptr = 1'b0; m_run = 0; cyc = 0;
      end else begin
        cyc++;
        e_rvalid = 2'b00; e_err = 2'b00;
        if (s_g != 2'b00) begin
          o  = s_g[1] ? 1 : 0;
          a1 = s_addr + 16'd1;
          if (s_addr == BAD_ADDR) begin
            e_err[o] = 1'b1; e_rdata = '0;
          end else if (s_we) begin
            m_mem[s_addr] = s_wdata[7:0];
            m_mem[a1]     = s_wdata[15:8];
          end else begin
            e_rvalid[o] = 1'b1; e_rdata = {m_mem[a1], m_mem[s_addr]};
          end
          m_run++;
          if (s_lock[o] && s_req[o] && m_run < MB) e_gnt = s_g;
          else begin
            e_gnt = 2'b00; m_ptr = (o == 0); m_run = 0;
          end
        end else if (s_req != 2'b00) begin
          o = s_req[m_ptr] ? int'(m_ptr) : int'(!m_ptr);
          e_gnt = (o == 1) ? 2'b10 : 2'b01;
          m_run = 0;
        end else begin
          e_gnt = 2'b00;
        end
      end
    end
  end

  // Mid-cycle side: compare DUT against the model, snapshot inputs, log.
  initial begin
    glog_t ge;
    rlog_t re;
    forever begin
      @(negedge clk);
      s_req = req; s_lock = lock; s_g = e_gnt;
      s_we    = e_gnt[1] ? we1 : we0;
      s_addr  = e_gnt[1] ? addr1 : addr0;
      s_wdata = e_gnt[1] ? wdata1 : wdata0;
      if (rst_n) begin
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("rvalid", 32'(rvalid), 32'(e_rvalid));
        chk("err", 32'(err), 32'(e_err));
        chk("rdata", 32'(rdata), 32'(e_rdata));
        if (e_gnt != 2'b00) begin
          chk("ramAddr", 32'(ramAddr), 32'(s_addr));
          chk("ramInData", 32'(ramInData), 32'(s_wdata));
          chk("ramWriteEn", 32'(ramWriteEn), 32'(s_we && (s_addr != BAD_ADDR)));
        end else begin
          chk("ramAddr_idle", 32'(ramAddr), 32'd0);
          chk("ramInData_idle", 32'(ramInData), 32'd0);
          chk("ramWriteEn_idle", 32'(ramWriteEn), 32'd0);
        end
        if (gnt != 2'b00) begin
          ge.cyc = cyc; ge.own = gnt[1] ? 1 : 0;
          glog.push_back(ge);
          $display("[TB] cyc %0d gnt=%b %s addr=%04h wdata=%04h wen=%0d",
                   cyc, gnt, (gnt[1] ? we1 : we0) ? "WR" : "RD",
                   ramAddr, ramInData, ramWriteEn);
        end
        if ((rvalid | err) != 2'b00) begin
          re.cyc = cyc; re.kind = {err, rvalid}; re.d = rdata;
          rlog.push_back(re);
        end
        if (ramWriteEn) we_count++;
        if (gnt == 2'b11) both_cnt++;
        if (req[0] && frq0 < 0) frq0 = cyc;
        if (req[1] && frq1 < 0) frq1 = cyc;
      end
    end
  end

  function automatic int g_own(input int i); return (i < glog.size()) ? glog[i].own : -1; endfunction
  function automatic int g_cyc(input int i); return (i < glog.size()) ? glog[i].cyc : -1000; endfunction
  function automatic int r_cyc(input int i); return (i < rlog.size()) ? rlog[i].cyc : -1000; endfunction
  function automatic logic [3:0] r_kind(input int i); return (i < rlog.size()) ? rlog[i].kind : 4'hF; endfunction
  function automatic logic [15:0] r_d(input int i); return (i < rlog.size()) ? rlog[i].d : 16'hDEAD; endfunction

  task automatic clear_logs();
    glog.delete(); rlog.delete();
    we_count = 0; both_cnt = 0; frq0 = -1; frq1 = -1;
  endtask

  task automatic reset_on();
    @(negedge clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic reset_off();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while ((q0.size() + q1.size()) > 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk("drain_budget", 32'(q0.size() + q1.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_logs();

    // 1: reset state, single write then read back
    reset_on(); reset_off();
    @(negedge clk); #1;
    chk("rst_gnt", 32'(gnt), 0);        chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_err", 32'(err), 0);        chk("rst_rdata", 32'(rdata), 0);
    chk("rst_ramAddr", 32'(ramAddr), 0); chk("rst_ramInData", 32'(ramInData), 0);
    chk("rst_ramWriteEn", 32'(ramWriteEn), 0);
    push(0, 16'h0010, 1'b1, 16'hBEEF, 1'b0);
    wait_done(20);
    chk("t1_ngnt", 32'(glog.size()), 1);
    chk("t1_owner", 32'(g_own(0)), 0);
    chk("t1_latency", 32'(g_cyc(0) - frq0), 1);
    chk("t1_wen_cycles", 32'(we_count), 1);
    chk("t1_mem10", 32'(mem[16'h0010]), 32'hEF);
    chk("t1_mem11", 32'(mem[16'h0011]), 32'hBE);
    clear_logs();
    push(0, 16'h0010, 1'b0, 16'h0000, 1'b0);
    wait_done(20);
    chk("t1_nresp", 32'(rlog.size()), 1);
    chk("t1_rkind", 32'(r_kind(0)), 32'b0001);
    chk("t1_rdata", 32'(r_d(0)), 32'hBEEF);

    // 2: both requesting from reset -> 0,1,0,1 with idle gaps
    reset_on();
    push(0, 16'h0100, 1'b0, 16'h0, 1'b0); push(0, 16'h0102, 1'b0, 16'h0, 1'b0);
    push(1, 16'h0200, 1'b0, 16'h0, 1'b0); push(1, 16'h0202, 1'b0, 16'h0, 1'b0);
    reset_off();
    wait_done(40);
    chk("t2_ngnt", 32'(glog.size()), 4);
    for (int i = 0; i < 4; i++) chk("t2_order", 32'(g_own(i)), 32'(i % 2));
    for (int i = 1; i < 4; i++) chk("t2_gap", 32'(g_cyc(i) - g_cyc(i-1)), 2);
    chk("t2_both", 32'(both_cnt), 0);

    // 3: locked loader burst of 10 writes with CPU waiting
    reset_on(); reset_off();
    for (int k = 0; k < 10; k++) push(1, 16'(16'h0300 + 2*k), 1'b1, 16'(16'hA000 + k), k < 9);
    n = 0;
    while (gnt[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t3_first_gnt1", 32'(gnt[1]), 1);
    push(0, 16'h0400, 1'b1, 16'h5555, 1'b0);
    wait_done(60);
    chk("t3_ngnt", 32'(glog.size()), 11);
    for (int i = 0; i < 8; i++) chk("t3_burst_owner", 32'(g_own(i)), 1);
    for (int i = 1; i < 8; i++) chk("t3_burst_gap", 32'(g_cyc(i) - g_cyc(i-1)), 1);
    chk("t3_cpu_owner", 32'(g_own(8)), 0);
    chk("t3_cpu_gap", 32'(g_cyc(8) - g_cyc(7)), 2);
    chk("t3_rest_owner9", 32'(g_own(9)), 1);
    chk("t3_rest_owner10", 32'(g_own(10)), 1);
    chk("t3_rest_gap9", 32'(g_cyc(9) - g_cyc(8)), 2);
    chk("t3_rest_gap10", 32'(g_cyc(10) - g_cyc(9)), 1);
    chk("t3_fair_bound", 32'((g_cyc(8) - frq0) <= MB + 1), 1);
    chk("t3_last_write", 32'({mem[16'h0313], mem[16'h0312]}), 32'hA009);
    chk("t3_cpu_write", 32'({mem[16'h0401], mem[16'h0400]}), 32'h5555);

    // 4: accesses at the top byte are rejected
    reset_on(); preload(16'hFFFF, 16'h6677); reset_off();
    push(0, 16'h0010, 1'b0, 16'h0000, 1'b0);
    push(0, 16'hFFFF, 1'b1, 16'h1234, 1'b0);
    push(0, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    wait_done(30);
    chk("t4_ngnt", 32'(glog.size()), 3);
    chk("t4_wen_cycles", 32'(we_count), 0);
    chk("t4_nresp", 32'(rlog.size()), 3);
    chk("t4_kind0", 32'(r_kind(0)), 32'b0001);
    chk("t4_data0", 32'(r_d(0)), 32'hBEEF);
    chk("t4_kind1", 32'(r_kind(1)), 32'b0100);
    chk("t4_data1", 32'(r_d(1)), 0);
    chk("t4_kind2", 32'(r_kind(2)), 32'b0100);
    chk("t4_data2", 32'(r_d(2)), 0);
    chk("t4_err_timing", 32'(r_cyc(1) - g_cyc(1)), 1);
    chk("t4_memFFFF", 32'(mem[16'hFFFF]), 32'h77);
    chk("t4_mem0000", 32'(mem[16'h0000]), 32'h66);

    // 5: reset during a granted write aborts it
    reset_on(); preload(16'h0040, 16'h2211); reset_off();
    push(0, 16'h0040, 1'b1, 16'hCAFE, 1'b0);
    n = 0;
    while (gnt[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t5_gnt_seen", 32'(gnt[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt), 0);
    chk("t5_async_wen", 32'(ramWriteEn), 0);
    chk("t5_async_addr", 32'(ramAddr), 0);
    chk("t5_async_indata", 32'(ramInData), 0);
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("t5_mem40", 32'(mem[16'h0040]), 32'h11);
    chk("t5_mem41", 32'(mem[16'h0041]), 32'h22);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    push(1, 16'h0600, 1'b0, 16'h0, 1'b0);
    push(0, 16'h0500, 1'b0, 16'h0, 1'b0);
    wait_done(30);
    chk("t5_first_owner", 32'(g_own(0)), 0);
    chk("t5_second_owner", 32'(g_own(1)), 1);

    // 6: locked read burst of three
    reset_on();
    preload(16'h0020, 16'h1111); preload(16'h0022, 16'h2222); preload(16'h0024, 16'h3333);
    reset_off();
    push(0, 16'h0020, 1'b0, 16'h0, 1'b1);
    push(0, 16'h0022, 1'b0, 16'h0, 1'b1);
    push(0, 16'h0024, 1'b0, 16'h0, 1'b0);
    wait_done(30);
    chk("t6_ngnt", 32'(glog.size()), 3);
    chk("t6_gap1", 32'(g_cyc(1) - g_cyc(0)), 1);
    chk("t6_gap2", 32'(g_cyc(2) - g_cyc(1)), 1);
    chk("t6_nresp", 32'(rlog.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t6_kind", 32'(r_kind(i)), 32'b0001);
      chk("t6_timing", 32'(r_cyc(i) - g_cyc(i)), 1);
    end
    chk("t6_data0", 32'(r_d(0)), 32'h1111);
    chk("t6_data1", 32'(r_d(1)), 32'h2222);
    chk("t6_data2", 32'(r_d(2)), 32'h3333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_data_port_arbiter.md
Name: ram_data_port_arbiter

Overview:
- Shares the RAM's single 16-bit data port (dataAddr/inData/write_en/dataOut) between two requesters.
  - Requester 0: CPU load/store unit.
  - Requester 1: program loader / peripheral DMA.
- Round-robin arbitration with optional locked bursts, a starvation bound, and rejection of unaligned top-of-memory accesses.
- Sits between the requesters and the RAM data port. The instruction port and PeripheralBuffer are untouched.

Parameters:
- ADDR_WIDTH, 16, byte address width; matches RAM.
- DATA_WIDTH, 16, data port width (two RAM bytes).
- MAX_BURST, 8, maximum consecutive grant cycles per ownership (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester transaction request; held with addr/we/wdata until gnt.
- lock  in  2  per-requester burst hold; sampled in that requester's grant cycle.
- we0, we1  in  1 each  write (1) / read (0).
- addr0, addr1  in  ADDR_WIDTH each  byte address.
- wdata0, wdata1  in  DATA_WIDTH each  write data.
- gnt  out  2  one-hot; the transaction is taken at the end of this cycle.
- rvalid  out  2  one-cycle pulse one cycle after a granted read.
- err  out  2  one-cycle pulse, same timing as rvalid, for a rejected access.
- rdata  out  DATA_WIDTH  registered read data for the requester flagged by rvalid.
- ramAddr  out  ADDR_WIDTH  to RAM dataAddr.
- ramInData  out  DATA_WIDTH  to RAM inData.
- ramWriteEn  out  1  to RAM write_en.
- ramDataOut  in  DATA_WIDTH  from RAM dataOut (combinational read).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=0, rrPtr=0, burstCnt=0.
  - gnt=0, rvalid=0, err=0, rdata=0.
  - ramAddr=0, ramInData=0, ramWriteEn=0.
  - Asserting reset mid-grant aborts the transaction: ramWriteEn drops immediately and no RAM write occurs.
- IDLE state:
  - No gnt; RAM outputs are 0.
  - At the clock edge, if any req is set: owner = rrPtr if req[rrPtr], else the other requester; go to GRANT; burstCnt=0.
- GRANT state:
  - gnt[owner]=1.
  - ramAddr/ramInData are muxed combinationally from the owner's inputs.
  - ramWriteEn = we_owner & ~bad, where bad = (addr_owner == all-ones), i.e. a 16-bit access straddling the top of memory.
- GRANT exit at the clock edge:
  - If lock[owner] & req[owner] & (burstCnt < MAX_BURST-1): stay in GRANT with the same owner, burstCnt++. The requester must present its next transaction in the following cycle.
  - Otherwise go to IDLE, rrPtr = ~owner, burstCnt=0.
- Latency and throughput:
  - Request to gnt is at least 1 cycle.
  - Unlocked throughput: one access per 2 cycles.
  - Locked throughput: one access per cycle, up to MAX_BURST accesses.
- Read completion: at the end of a granted read cycle, rdata <= ramDataOut and rvalid[owner] pulses next cycle. rdata holds its value until the next read.
- Write completion: the RAM write lands at the end of the gnt cycle. rvalid is not pulsed.
- Rejected access (bad=1):
  - gnt is still given.
  - No write; rdata <= 0.
  - err[owner] pulses next cycle; rvalid stays 0.
- Fairness:
  - Simultaneous requests in IDLE go to rrPtr, which starts at 0 after reset.
  - A waiting requester is granted within MAX_BURST+1 cycles.
- If req[owner] drops while lock is set in the grant cycle, the block exits to IDLE. req must not drop before gnt; that is a protocol violation and the behaviour is undefined.

Decomposition:
- Shared package: ADDR_WIDTH/DATA_WIDTH defaults, state encoding (IDLE=1'b0, GRANT=1'b1), the BAD_ADDR constant (all-ones), and requester index constants (REQ_CPU=0, REQ_LOADER=1).
- One natural sub-module: rr_pick2 (combinational 2-way round-robin selector: req[1:0], rrPtr -> owner, any).
- The FSM, burst counter, mux and response registers stay in the top module.

Test Plan:
- Reset then req0 write, addr0=0x0010, wdata0=0xBEEF: gnt[0] in cycle 2, ramWriteEn=1 for one cycle, mem[0x10]=EF, mem[0x11]=BE. A subsequent read of 0x0010 gives rvalid[0] with rdata=0xBEEF.
- req0 and req1 both asserted from reset: gnt order 0,1,0,1 with one idle cycle between grants; no cycle has both gnt bits set.
- req1 with lock=1 and 10 back-to-back writes while req0 waits (MAX_BURST=8): 8 consecutive gnt[1] cycles, then IDLE, then gnt[0]; the remaining loader writes complete afterwards.
- req0 write to addr 0xFFFF: gnt[0] pulses, ramWriteEn stays 0, err[0] pulses next cycle, memory unchanged. The same read gives err[0] with rdata=0.
- rst_n asserted low during a GRANT write cycle: outputs go to 0 asynchronously, the target byte is unchanged, and after release the block is in IDLE with rrPtr=0.
- Locked read burst of 3 from req0, addresses 0x0020/0x0022/0x0024: gnt in 3 consecutive cycles, rvalid[0] in the 3 cycles following, with rdata matching the preloaded values in order.
